// File: rtl/cic_timebase_pkg.sv
// +----------------------------------------------------------------------------+
// | cic_timebase_pkg : shared types, constants and helpers for the CIC timebase |
// | Build macro: CIC_TB_STAGGER_EN (per-channel phase stagger) | Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

package cic_timebase_pkg;

  localparam int unsigned MIN_DECIMATION     = 2;
  localparam int unsigned PKG_MAX_DECIMATION = 256;

  function automatic int unsigned cnt_width(input int unsigned max_r);
    return $clog2(max_r) + 1;
  endfunction

  localparam int unsigned RATIO_W = cnt_width(PKG_MAX_DECIMATION);

  typedef logic [RATIO_W-1:0] ratio_t;

`ifdef CIC_TB_STAGGER_EN
  localparam bit STAGGER_ON = 1'b1;
`else
  localparam bit STAGGER_ON = 1'b0;
`endif

  function automatic int unsigned clamp_ratio(input int unsigned req, input int unsigned max_r);
    if (req < MIN_DECIMATION) return MIN_DECIMATION;
    if (req > max_r)          return max_r;
    return req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_phase_counter.sv
// +----------------------------------------------------------------------------+
// | cic_phase_counter : one channel phase register with clock/strobe decode     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cic_phase_counter #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             load,
  input  logic             enable,
  input  logic             stb_allow,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] ratio,
  output logic             divided_clk,
  output logic             sample_stb
);

  logic [CNT_W-1:0] phase_q, phase_d;
  logic             at_end;

  assign at_end      = (phase_q == ratio - CNT_W'(1));
  assign divided_clk = (phase_q >= (ratio >> 1));
  assign sample_stb  = stb_allow & at_end;

  // Load covers reset, sync and the channel-0 wrap realign.
  always_comb begin
    phase_d = phase_q;
    if (load)        phase_d = load_val;
    else if (enable) phase_d = at_end ? '0 : phase_q + CNT_W'(1);
  end

  always_ff @(negedge clk) begin
    phase_q <= phase_d;
  end

endmodule

`default_nettype wire

// File: rtl/cic_decim_timebase.sv
// +----------------------------------------------------------------------------+
// | cic_decim_timebase : shared decimation timebase for NUM_CH CIC channels     |
// | Build macro: CIC_TB_STAGGER_EN (per-channel phase stagger) | Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module cic_decim_timebase
  import cic_timebase_pkg::*;
#(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned MAX_DECIMATION     = 256,
  parameter int unsigned DEFAULT_DECIMATION = 256,
  parameter int unsigned CNT_W              = cnt_width(MAX_DECIMATION),
  parameter int unsigned STAGGER_STEP       = 16,
  parameter int unsigned FRAME_W            = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sync,
  input  logic [CNT_W-1:0]   dec_ratio,
  output logic [NUM_CH-1:0]  divided_clk,
  output logic [NUM_CH-1:0]  sample_stb,
  output logic [CNT_W-1:0]   ratio_active,
  output logic [FRAME_W-1:0] frame_cnt
);

  logic [CNT_W-1:0]   ratio_active_q, ratio_active_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   rc;
  logic [CNT_W-1:0]   load_ratio;
  logic               wrap0;
  logic               load;
  logic               stb_allow;

  assign rc         = CNT_W'(clamp_ratio(32'(dec_ratio), MAX_DECIMATION));
  assign stb_allow  = reset_n & ~sync & enable;
  assign wrap0      = sample_stb[0];
  assign load       = ~reset_n | sync | wrap0;
  // Load offsets are sized against the ratio that will be active after this edge.
  assign load_ratio = reset_n ? rc : CNT_W'(DEFAULT_DECIMATION);

  assign ratio_active = ratio_active_q;
  assign frame_cnt    = frame_cnt_q;

  always_comb begin
    ratio_active_d = ratio_active_q;
    frame_cnt_d    = frame_cnt_q;
    if (sync) begin
      ratio_active_d = rc;
      frame_cnt_d    = '0;
    end else if (wrap0) begin
      ratio_active_d = rc;
      frame_cnt_d    = frame_cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      ratio_active_q <= CNT_W'(DEFAULT_DECIMATION);
      frame_cnt_q    <= '0;
    end else begin
      ratio_active_q <= ratio_active_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam int unsigned OFFSET = STAGGER_ON ? int'(ch) * STAGGER_STEP : 0;
    logic [CNT_W-1:0] load_val;

    assign load_val = (OFFSET < 32'(load_ratio)) ? CNT_W'(OFFSET) : '0;

    cic_phase_counter #(
      .CNT_W (CNT_W)
    ) u_phase (
      .clk         (clk),
      .load        (load),
      .enable      (enable),
      .stb_allow   (stb_allow),
      .load_val    (load_val),
      .ratio       (ratio_active_q),
      .divided_clk (divided_clk[ch]),
      .sample_stb  (sample_stb[ch])
    );
  end

endmodule

`default_nettype wire
